// File: rtl/twin_reg_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// twin_reg_arb_pkg
// Shared definitions for the twin-register arbiter:
//   - arb_state_e        : bank ownership state (idle / owned by 0 / owned by 1)
//   - TWIN_WIDTH_DEFAULT : default data width of q1/q2 and the write data ports
//   - preset_ones()      : all-ones preset pattern for a given width (<= 64)
// -----------------------------------------------------------------------------
package twin_reg_arb_pkg;

  localparam int unsigned TWIN_WIDTH_DEFAULT = 32'd8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_OWN0 = 2'd1,
    ST_OWN1 = 2'd2
  } arb_state_e;

  // Returns a 64-bit word whose low w bits are set; callers cast to their width.
  function automatic logic [63:0] preset_ones(input int unsigned w);
    logic [63:0] r;
    if (w >= 32'd64) begin
      r = {64{1'b1}};
    end else begin
      r = (64'd1 << w) - 64'd1;
    end
    return r;
  endfunction

endpackage

// File: rtl/twin_reg_arbiter_if.sv
// -----------------------------------------------------------------------------
// twin_reg_arbiter_if
// Bundles the requester handshake, write beats, preset command and the
// register/status outputs of the twin-register arbiter.
//   req[k], wr[k], sel[k], last[k] : per-requester handshake and beat controls
//   wdata0 / wdata1                : write data of requester 0 / 1
//   set_req                        : preset command (loads all-ones)
//   gnt, busy, timeout             : ownership status
//   q1, q2                         : the shared register pair
// Modports: master = write masters / system side, slave = the arbiter.
// -----------------------------------------------------------------------------
interface twin_reg_arbiter_if
  import twin_reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH = TWIN_WIDTH_DEFAULT
);

  logic [1:0]       req;
  logic [1:0]       wr;
  logic [1:0]       sel;
  logic [1:0]       last;
  logic [WIDTH-1:0] wdata0;
  logic [WIDTH-1:0] wdata1;
  logic             set_req;
  logic [1:0]       gnt;
  logic [WIDTH-1:0] q1;
  logic [WIDTH-1:0] q2;
  logic             busy;
  logic             timeout;

  modport master (
    output req, wr, sel, last, wdata0, wdata1, set_req,
    input  gnt, q1, q2, busy, timeout
  );

  modport slave (
    input  req, wr, sel, last, wdata0, wdata1, set_req,
    output gnt, q1, q2, busy, timeout
  );

endinterface

// File: rtl/twin_reg_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Combinational two-way round-robin picker. The pointer register lives in the
// parent; this block only chooses.
//   req_i[1:0] : request vector
//   ptr_i      : 0 favours requester 0, 1 favours requester 1
//   pick_o[1:0]: one-hot pick, or 2'b00 when nobody requests
// -----------------------------------------------------------------------------
module rr_arb2 (
  input  logic [1:0] req_i,
  input  logic       ptr_i,
  output logic [1:0] pick_o
);

  // Favoured requester wins if requesting, otherwise the other one.
  always_comb begin
    pick_o = 2'b00;
    if (ptr_i == 1'b0) begin
      if (req_i[0]) begin
        pick_o = 2'b01;
      end else if (req_i[1]) begin
        pick_o = 2'b10;
      end else begin
        pick_o = 2'b00;
      end
    end else begin
      if (req_i[1]) begin
        pick_o = 2'b10;
      end else if (req_i[0]) begin
        pick_o = 2'b01;
      end else begin
        pick_o = 2'b00;
      end
    end
  end

endmodule

// File: rtl/twin_reg_arbiter.sv
// -----------------------------------------------------------------------------
// twin_reg_arbiter
// Shares one pair of WIDTH-bit registers (q1/q2) between two write masters.
// A requester gains exclusive ownership through req/gnt, writes single-cycle
// beats to q1 (sel=0) or q2 (sel=1) and releases with a last beat or by
// dropping req. A preset command loads all-ones into both registers while the
// bank is unowned; a preset arriving during ownership is held pending and
// applied on the first idle edge, ahead of any waiting requester.
//
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (release expected synchronous to clk)
//   bus : twin_reg_arbiter_if.slave (req/wr/sel/last/wdata0/wdata1/set_req in,
//         gnt/q1/q2/busy/timeout out)
//
// Optional feature (macro TWIN_ARB_TIMEOUT_EN): bounded ownership. A hold
// counter forces release after MAX_HOLD owned cycles and pulses timeout.
// Without the macro no counter exists and timeout is constant 0.
// -----------------------------------------------------------------------------
module twin_reg_arbiter
  import twin_reg_arb_pkg::*;
#(
  parameter int unsigned WIDTH    = TWIN_WIDTH_DEFAULT,
  parameter int unsigned MAX_HOLD = 32'd16
) (
  input  logic              clk,
  input  logic              rst,
  twin_reg_arbiter_if.slave bus
);

  localparam logic [WIDTH-1:0] PRESET_VAL = WIDTH'(preset_ones(WIDTH));

  if (MAX_HOLD < 32'd2) begin : g_bad_max_hold
    $error("twin_reg_arbiter: MAX_HOLD must be at least 2");
  end
  if (WIDTH > 32'd64) begin : g_bad_width
    $error("twin_reg_arbiter: WIDTH must not exceed 64");
  end

  arb_state_e       state_q, state_d;
  logic             ptr_q, ptr_d;
  logic             set_pend_q, set_pend_d;
  logic [WIDTH-1:0] q1_q, q1_d;
  logic [WIDTH-1:0] q2_q, q2_d;

  logic [1:0]       pick_s;
  logic             own_req_s;
  logic             own_wr_s;
  logic             own_sel_s;
  logic             own_last_s;
  logic [WIDTH-1:0] own_wdata_s;
  logic             normal_rel_s;
  logic             force_rel_s;
  logic [1:0]       gnt_s;
  logic             busy_s;

  rr_arb2 u_rr_arb2 (
    .req_i  (bus.req),
    .ptr_i  (ptr_q),
    .pick_o (pick_s)
  );

  // Select the owning requester's controls; the other requester is ignored.
  always_comb begin
    if (state_q == ST_OWN1) begin
      own_req_s   = bus.req[1];
      own_wr_s    = bus.wr[1];
      own_sel_s   = bus.sel[1];
      own_last_s  = bus.last[1];
      own_wdata_s = bus.wdata1;
    end else begin
      own_req_s   = bus.req[0];
      own_wr_s    = bus.wr[0];
      own_sel_s   = bus.sel[0];
      own_last_s  = bus.last[0];
      own_wdata_s = bus.wdata0;
    end
  end

  // A last beat ends ownership; so does dropping req without one (abort).
  assign normal_rel_s = (own_wr_s & own_last_s) | ~own_req_s;

`ifdef TWIN_ARB_TIMEOUT_EN
  localparam int unsigned HOLD_W = $clog2(MAX_HOLD) + 32'd1;

  logic [HOLD_W-1:0] hold_q, hold_d;
  logic              timeout_q, timeout_d;

  // Hold counter: zero while idle (so it starts at zero on grant), counts owned cycles.
  always_comb begin
    if (state_q == ST_IDLE) begin
      hold_d = '0;
    end else begin
      hold_d = hold_q + HOLD_W'(1);
    end
  end

  assign force_rel_s = (state_q != ST_IDLE) && (hold_q == HOLD_W'(MAX_HOLD - 32'd1));
  // Only flag a timeout when the release was not already a normal one.
  assign timeout_d   = force_rel_s & ~normal_rel_s;

  // Hold counter and timeout pulse registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q    <= '0;
      timeout_q <= 1'b0;
    end else begin
      hold_q    <= hold_d;
      timeout_q <= timeout_d;
    end
  end

  assign bus.timeout = timeout_q;
`else
  assign force_rel_s = 1'b0;
  assign bus.timeout = 1'b0;
`endif

  // Next-state, pointer, pending-preset and register-bank update logic.
  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    set_pend_d = set_pend_q;
    q1_d       = q1_q;
    q2_d       = q2_q;
    case (state_q)
      ST_IDLE: begin
        // Preset has priority and blocks granting on this edge.
        if (bus.set_req || set_pend_q) begin
          q1_d       = PRESET_VAL;
          q2_d       = PRESET_VAL;
          set_pend_d = 1'b0;
        end else if (pick_s[0]) begin
          state_d = ST_OWN0;
        end else if (pick_s[1]) begin
          state_d = ST_OWN1;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_OWN0, ST_OWN1: begin
        if (bus.set_req) begin
          set_pend_d = 1'b1;
        end else begin
          set_pend_d = set_pend_q;
        end
        if (own_wr_s) begin
          if (own_sel_s) begin
            q2_d = own_wdata_s;
          end else begin
            q1_d = own_wdata_s;
          end
        end else begin
          q1_d = q1_q;
          q2_d = q2_q;
        end
        // Any release hands priority to the other requester.
        if (normal_rel_s || force_rel_s) begin
          state_d = ST_IDLE;
          ptr_d   = (state_q == ST_OWN0);
        end else begin
          state_d = state_q;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State, pointer, pending preset and register bank.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_IDLE;
      ptr_q      <= 1'b0;
      set_pend_q <= 1'b0;
      q1_q       <= '0;
      q2_q       <= '0;
    end else begin
      state_q    <= state_d;
      ptr_q      <= ptr_d;
      set_pend_q <= set_pend_d;
      q1_q       <= q1_d;
      q2_q       <= q2_d;
    end
  end

  // Grant and busy decode straight from the state register.
  always_comb begin
    gnt_s  = 2'b00;
    busy_s = 1'b0;
    case (state_q)
      ST_OWN0: begin
        gnt_s  = 2'b01;
        busy_s = 1'b1;
      end
      ST_OWN1: begin
        gnt_s  = 2'b10;
        busy_s = 1'b1;
      end
      default: begin
        gnt_s  = 2'b00;
        busy_s = 1'b0;
      end
    endcase
  end

  assign bus.gnt  = gnt_s;
  assign bus.busy = busy_s;
  assign bus.q1   = q1_q;
  assign bus.q2   = q2_q;

endmodule

// File: tb/tb_twin_reg_arbiter.sv
// -----------------------------------------------------------------------------
// tb_twin_reg_arbiter
// Self-checking bench for twin_reg_arbiter: a vector table of per-cycle inputs
// and expected outputs (queued as a scoreboard and compared after each edge),
// plus hand-written sequences for asynchronous reset and, when
// TWIN_ARB_TIMEOUT_EN is defined, the forced-release timeout.
// -----------------------------------------------------------------------------
module tb_twin_reg_arbiter;
  import twin_reg_arb_pkg::*;

  localparam int unsigned W  = 32'd8;
  localparam int unsigned MH = 32'd4;
  localparam int          NV = 21;

  logic clk;
  logic rst;

  twin_reg_arbiter_if #(.WIDTH(W)) bus ();

  twin_reg_arbiter #(.WIDTH(W), .MAX_HOLD(MH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic       pre_rst;
    logic [1:0] req;
    logic [1:0] wr;
    logic [1:0] sel;
    logic [1:0] last;
    logic       set_req;
    logic [7:0] wd0;
    logic [7:0] wd1;
    logic [1:0] e_gnt;
    logic [7:0] e_q1;
    logic [7:0] e_q2;
  } vec_t;

  typedef struct {
    logic [1:0] gnt;
    logic [7:0] q1;
    logic [7:0] q2;
    logic       busy;
    logic       timeout;
    int         idx;
  } exp_t;

  vec_t vecs [NV];
  exp_t sb_q [$];
  exp_t e;
  int   n_pass  = 0;
  int   n_total = 0;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic vec_t mk(input logic pr, input logic [1:0] req, input logic [1:0] wr,
                              input logic [1:0] sel, input logic [1:0] last, input logic sr,
                              input logic [7:0] wd0, input logic [7:0] wd1,
                              input logic [1:0] eg, input logic [7:0] e1, input logic [7:0] e2);
    vec_t v;
    v.pre_rst = pr;  v.req = req;  v.wr = wr;   v.sel = sel; v.last = last;
    v.set_req = sr;  v.wd0 = wd0;  v.wd1 = wd1;
    v.e_gnt   = eg;  v.e_q1 = e1;  v.e_q2 = e2;
    return v;
  endfunction

  task automatic idle_inputs();
    bus.req     = 2'b00;
    bus.wr      = 2'b00;
    bus.sel     = 2'b00;
    bus.last    = 2'b00;
    bus.set_req = 1'b0;
    bus.wdata0  = 8'h00;
    bus.wdata1  = 8'h00;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    //                 pr    req    wr     sel    last   sr    wd0    wd1    gnt    q1     q2
    vecs[0]  = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00);
    vecs[1]  = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b00, 1'b0, 8'h3C, 8'h00, 2'b01, 8'h3C, 8'h00);
    vecs[2]  = mk(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 8'hA5, 8'h00, 2'b00, 8'h3C, 8'hA5);
    vecs[3]  = mk(1'b1, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b01, 8'h00, 8'h00);
    vecs[4]  = mk(1'b0, 2'b11, 2'b11, 2'b00, 2'b00, 1'b0, 8'h11, 8'hEE, 2'b01, 8'h11, 8'h00);
    vecs[5]  = mk(1'b0, 2'b11, 2'b10, 2'b11, 2'b10, 1'b0, 8'h00, 8'h77, 2'b01, 8'h11, 8'h00);
    vecs[6]  = mk(1'b0, 2'b11, 2'b01, 2'b01, 2'b01, 1'b0, 8'h22, 8'h00, 2'b00, 8'h11, 8'h22);
    vecs[7]  = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b10, 8'h11, 8'h22);
    vecs[8]  = mk(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b10, 8'h11, 8'h22);
    vecs[9]  = mk(1'b0, 2'b11, 2'b10, 2'b10, 2'b10, 1'b0, 8'h00, 8'h5A, 2'b00, 8'h11, 8'h5A);
    vecs[10] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 8'hFF, 8'hFF);
    vecs[11] = mk(1'b0, 2'b01, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b01, 8'hFF, 8'hFF);
    vecs[12] = mk(1'b0, 2'b01, 2'b01, 2'b00, 2'b01, 1'b0, 8'hC3, 8'h00, 2'b00, 8'hC3, 8'hFF);
    vecs[13] = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b10, 8'hC3, 8'hFF);
    vecs[14] = mk(1'b0, 2'b10, 2'b10, 2'b00, 2'b00, 1'b0, 8'h00, 8'h66, 2'b10, 8'h66, 8'hFF);
    vecs[15] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 8'h66, 8'hFF);
    vecs[16] = mk(1'b0, 2'b11, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b01, 8'h66, 8'hFF);
    vecs[17] = mk(1'b0, 2'b01, 2'b01, 2'b01, 2'b01, 1'b0, 8'h99, 8'h00, 2'b00, 8'h66, 8'h99);
    vecs[18] = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1, 8'h00, 8'h00, 2'b00, 8'hFF, 8'hFF);
    vecs[19] = mk(1'b0, 2'b10, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b10, 8'hFF, 8'hFF);
    vecs[20] = mk(1'b0, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 8'h00, 8'h00, 2'b00, 8'hFF, 8'hFF);

    // Reset state
    idle_inputs();
    rst = 1'b1;
    #3 rst = 1'b0;
    @(negedge clk);
    chk("reset gnt",     bus.gnt,     8'h00);
    chk("reset q1",      bus.q1,      8'h00);
    chk("reset q2",      bus.q2,      8'h00);
    chk("reset busy",    bus.busy,    8'h00);
    chk("reset timeout", bus.timeout, 8'h00);
    @(negedge clk);
    rst = 1'b1;

    // Vector table through a scoreboard queue
    for (int i = 0; i < NV; i++) begin
      if (vecs[i].pre_rst) begin
        idle_inputs();
        do_reset();
      end
      bus.req     = vecs[i].req;
      bus.wr      = vecs[i].wr;
      bus.sel     = vecs[i].sel;
      bus.last    = vecs[i].last;
      bus.set_req = vecs[i].set_req;
      bus.wdata0  = vecs[i].wd0;
      bus.wdata1  = vecs[i].wd1;
      sb_q.push_back('{gnt: vecs[i].e_gnt, q1: vecs[i].e_q1, q2: vecs[i].e_q2,
                       busy: |vecs[i].e_gnt, timeout: 1'b0, idx: i});
      cycle();
      e = sb_q.pop_front();
      chk($sformatf("v%0d gnt", e.idx),     bus.gnt,     e.gnt);
      chk($sformatf("v%0d q1", e.idx),      bus.q1,      e.q1);
      chk($sformatf("v%0d q2", e.idx),      bus.q2,      e.q2);
      chk($sformatf("v%0d busy", e.idx),    bus.busy,    e.busy);
      chk($sformatf("v%0d timeout", e.idx), bus.timeout, e.timeout);
    end
    chk("scoreboard drained", 8'(sb_q.size()), 8'h00);

    // Asynchronous reset in the middle of a beat, between clock edges
    idle_inputs();
    bus.req = 2'b01;
    cycle();
    chk("arst pre gnt", bus.gnt, 8'h01);
    bus.wr     = 2'b01;
    bus.sel    = 2'b00;
    bus.wdata0 = 8'hAB;
    #2 rst = 1'b0;
    #1;
    chk("arst q1 now",   bus.q1,   8'h00);
    chk("arst q2 now",   bus.q2,   8'h00);
    chk("arst gnt now",  bus.gnt,  8'h00);
    chk("arst busy now", bus.busy, 8'h00);
    @(posedge clk);
    #1;
    chk("arst q1 held", bus.q1, 8'h00);
    idle_inputs();
    @(negedge clk);
    rst = 1'b1;

`ifdef TWIN_ARB_TIMEOUT_EN
    // Forced release after MH owned cycles, then the waiting requester 1
    bus.req = 2'b11;
    cycle();
    chk("to grant0", bus.gnt, 8'h01);
    for (int c = 1; c <= 3; c++) begin
      cycle();
      chk($sformatf("to own c%0d gnt", c), bus.gnt, 8'h01);
      chk($sformatf("to own c%0d timeout", c), bus.timeout, 8'h00);
    end
    cycle();
    chk("to release gnt", bus.gnt, 8'h00);
    chk("to pulse",       bus.timeout, 8'h01);
    cycle();
    chk("to next gnt",    bus.gnt, 8'h02);
    chk("to pulse end",   bus.timeout, 8'h00);
    idle_inputs();
    cycle();
    chk("to abort gnt",   bus.gnt, 8'h00);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/twin_reg_arbiter.md
Name: twin_reg_arbiter

Overview:
- Controller that shares one pair of WIDTH-bit registers (q1/q2) between two requesters.
- A requester gets exclusive ownership via a req/gnt handshake and issues single-cycle write beats targeting q1 or q2, ending with a last beat.
- A system-level preset command (set_req) loads all-ones into both registers, but only while the bank is unowned.
- Sits between the two write masters and the register pair, replacing direct, contended writes to the twin registers.

Parameters:
- WIDTH, 8, data width of each register and each wdata port.
- MAX_HOLD, 16, maximum cycles an owner may hold the grant; used only with TWIN_ARB_TIMEOUT_EN; must be ≥2.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-low; asserting it low resets immediately, release is synchronous to clk.
- req  input  2  req[k]: requester k wants ownership; held until its last beat.
- wr  input  2  wr[k]: write beat valid from requester k.
- sel  input  2  sel[k]: target for requester k's beat; 0 selects q1, 1 selects q2.
- wdata0  input  WIDTH  write data, requester 0.
- wdata1  input  WIDTH  write data, requester 1.
- last  input  2  last[k]: the current beat from k is its final beat.
- set_req  input  1  preset command pulse or level.
- gnt  output  2  one-hot-or-zero grant, registered.
- q1  output  WIDTH  register 1.
- q2  output  WIDTH  register 2.
- busy  output  1  high while any grant is held.
- timeout  output  1  one-cycle pulse on forced release.

Behaviour:
- Reset (rst low): q1=q2=0, gnt=00, busy=0, timeout=0, state IDLE, set_pend=0, RR pointer favours requester 0. Reset mid-ownership aborts the ownership; no partial write occurs.
- States: IDLE, OWN0, OWN1. busy = (state != IDLE). gnt[k] = (state == OWNk).
- IDLE, evaluated at each edge:
  - If set_req or set_pend is high: q1 and q2 load all-ones, set_pend clears, state stays IDLE, and no grant is issued that edge.
  - Else if any req bit is high: grant the requester favoured by the RR pointer if it is requesting, otherwise the other one. The state moves to OWNk at this edge, so gnt is high in the following cycle.
  - Latency: req high before edge n → gnt high after edge n → earliest accepted beat at edge n+1.
- OWNk, at each edge:
  - If wr[k] is high: the selected register loads wdatak and the other register holds.
  - If wr[k] and last[k] are both high: write, then go to IDLE. gnt drops after that edge, and the RR pointer favours the other requester.
  - If req[k] drops without last: abort. Go to IDLE, no write unless wr[k] is also high that cycle, and update the pointer as for a normal release.
  - wr, sel, wdata and last from the non-granted requester are ignored entirely.
- set_req arriving while in OWNk sets set_pend. The preset is applied on the first IDLE edge, ahead of any waiting requester.
- Back-to-back ownership: the bank always spends one IDLE cycle between grants, giving a minimum one-cycle gap.
- Simultaneous req[0] and req[1] in IDLE: the pointer decides; over time the two requesters alternate.
- No register changes except by a granted write, the preset, or reset.

Optional Feature:
- Macro: TWIN_ARB_TIMEOUT_EN.
- With the macro defined:
  - A hold counter clears on grant and increments every OWN cycle.
  - When it reaches MAX_HOLD-1 and no last beat is accepted that cycle, the state is forced to IDLE.
  - A beat with wr high in that cycle is still written.
  - timeout pulses high for one cycle after that edge, and the pointer moves to the other requester.
- Without the macro: no counter is built, timeout is tied to 0, and ownership is unbounded.

Decomposition:
- Package twin_reg_arb_pkg holds:
  - the state enum (IDLE, OWN0, OWN1);
  - the default WIDTH constant;
  - an all-ones preset helper function parameterised by width.
- Sub-module rr_arb2: a two-way round-robin picker.
  - Inputs: req[1:0], pointer.
  - Outputs: one-hot pick.
  - Combinational.
  - The pointer register stays in the parent.

Test Plan:
- Reset then req=01; beats: (sel0=0, wdata0=8'h3C), then (sel0=1, wdata0=8'hA5, last) → gnt=01 one cycle after req; q1=3C, q2=A5; gnt=00 after the last beat.
- req=11 from IDLE after reset → requester 0 is granted first. After its last beat, requester 1 is granted following a single IDLE cycle; requester 1's wr pulses during OWN0 leave q1/q2 unchanged.
- set_req pulse during OWN1 → registers untouched until release; the first IDLE edge gives q1=q2=8'hFF; a pending req[0] is granted only after that edge.
- req[1] dropped mid-ownership with no last → gnt=00 next cycle; registers keep the last written values; the next contention favours requester 0.
- rst driven low asynchronously mid-beat (between edges) → q1=q2=0 and gnt=00 immediately, with no clock edge required.
- With TWIN_ARB_TIMEOUT_EN and MAX_HOLD=4: hold req[0] with no last → gnt drops after the 4th OWN0 cycle, timeout pulses once, and a waiting req[1] is granted next.
